flight_stage_sequencer: RTL
===========================

Name: flight_stage_sequencer

Overview:
- Mission-phase controller for the two-stage trajectory datapath (altitude calculator + stage models).
- Sequences launch, stage-1 burn, coast, separation, stage-2 burn and orbit insertion.
- Gates integration steps to the altitude calculator with a req/ack handshake, drives thrust/stage selection, and terminates on target altitude or burn exhaustion.

Parameters:
- N, 64, datapath width of current_Altitude.
- STAGE1_BURN, 160, acked steps of stage-1 burn.
- STAGE2_BURN, 400, max acked steps of stage-2 burn.
- COAST_CYCLES, 8, clock cycles of unpowered coast before separation.
- SEP_CYCLES, 4, clock cycles of separation hold; no steps issued.
- TARGETALTITUDE, 188000, target altitude in metres.
- ALT_SCALE, 1_000_000_000, fixed-point scale of current_Altitude (9 fractional digits). Threshold = TARGETALTITUDE*ALT_SCALE as an N-bit integer constant, no real arithmetic.
- WDOG_CYCLES, 1024, step-ack timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- resetb  in  1  synchronous active-low reset.
- launch  in  1  launch command, sampled in IDLE only.
- abort  in  1  abort command.
- current_Altitude  in  N  altitude from the calculator, same scale as threshold.
- step_ack  in  1  calculator accepted the current integration step.
- step_req  out  1  request one integration step.
- thrust_en  out  1  engine thrust applied.
- stage_sel  out  2  active stage: 0 none, 1 stage-1, 2 stage-2.
- sep_pulse  out  1  one-cycle separation strobe.
- state  out  3  FSM state code.
- burn_count  out  16  acked steps (or cycles) in the current phase.
- done  out  1  orbit reached, sticky.
- fault  out  1  abort/failure, sticky.

Behaviour:
- Reset (resetb=0 at posedge clk): state=IDLE, all outputs 0, counters 0.
- Only one clock; every output is registered.
- State codes: IDLE 0, STAGE1 1, COAST 2, SEPARATE 3, STAGE2 4, ORBIT 5, ABORT 6.
- Handshake:
  - step_req is high in STAGE1, COAST and STAGE2 and low elsewhere.
  - A step completes in any cycle where step_req&&step_ack; ack may arrive in the same cycle req rises.
  - step_ack while step_req=0 is ignored.
- burn_count:
  - Clears to 0 on every state entry.
  - STAGE1/STAGE2: +1 per completed step.
  - COAST/SEPARATE: +1 per clock.
  - Saturates at 16'hFFFF.
- IDLE: launch=1 -> STAGE1 next cycle. abort is ignored in IDLE.
- STAGE1: thrust_en=1, stage_sel=1.
  - On the completed step where current_Altitude >= threshold -> ORBIT.
  - Else on the completed step making count==STAGE1_BURN -> COAST.
- COAST: thrust_en=0, stage_sel=1; steps still issued. After COAST_CYCLES clocks -> SEPARATE.
- SEPARATE: step_req=0, thrust_en=0, stage_sel=0.
  - sep_pulse=1 in the first SEPARATE cycle only.
  - After SEP_CYCLES clocks -> STAGE2.
- STAGE2: thrust_en=1, stage_sel=2.
  - Completed step with current_Altitude >= threshold -> ORBIT.
  - Else completed step with count==STAGE2_BURN -> ABORT (burn exhausted).
  - If altitude reached and burn exhausted on the same step, ORBIT wins.
- ORBIT: done=1, thrust_en=0, step_req=0. Exit only by reset.
- ABORT: fault=1, thrust_en=0, step_req=0, stage_sel=0. Exit only by reset; launch is ignored.
- abort=1 in any state other than IDLE/ORBIT/ABORT -> ABORT next cycle, with priority over all other transitions.
- Altitude is compared only on completed steps, unsigned, N bits.
- Reset mid-flight returns to IDLE the next edge regardless of handshake; a pending req is dropped.

Optional Feature:
- STEP_WATCHDOG_EN defined:
  - A counter increments each cycle step_req=1 && step_ack=0, and clears on a completed step or when step_req=0.
  - Reaching WDOG_CYCLES -> ABORT with fault=1.
- Not defined: no watchdog logic; a stalled ack holds the FSM indefinitely.

Test Plan:
- Params STAGE1_BURN=5, COAST_CYCLES=3, SEP_CYCLES=2, STAGE2_BURN=10, step_ack tied 1, altitude ramps to threshold at stage-2 step 4 -> state sequence 1(5 cycles),2(3),3(2),4(4),5; sep_pulse exactly once; done=1, fault=0.
- Same params, altitude never reaches threshold -> ABORT after 10 stage-2 steps, fault=1, done=0.
- step_ack high only every 3rd cycle in STAGE1 -> burn_count advances only on acked cycles; COAST entered after 15 cycles.
- abort asserted in STAGE2 step 2 while step_req=1 -> ABORT next cycle, thrust_en=0, step_req=0; a later launch is ignored.
- launch and abort together in IDLE -> STAGE1 entered; abort one cycle later -> ABORT. Reset mid-COAST -> IDLE, all outputs 0.
- With STEP_WATCHDOG_EN and WDOG_CYCLES=8, step_ack held 0 in STAGE1 -> ABORT exactly 8 cycles after req rises; without the macro, state stays STAGE1.

Source files
------------

// File: rtl/flight_stage_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flight_stage_sequencer_if : step handshake, flight commands and status   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface flight_stage_sequencer_if #(
  parameter int N = 64
);
  logic         launch;
  logic         abort;
  logic [N-1:0] current_Altitude;
  logic         step_ack;
  logic         step_req;
  logic         thrust_en;
  logic [1:0]   stage_sel;
  logic         sep_pulse;
  logic [2:0]   state;
  logic [15:0]  burn_count;
  logic         done;
  logic         fault;

  // master is the sequencer side: it issues steps and reports status
  modport master (
    input  launch, abort, current_Altitude, step_ack,
    output step_req, thrust_en, stage_sel, sep_pulse, state, burn_count, done, fault
  );

  modport slave (
    output launch, abort, current_Altitude, step_ack,
    input  step_req, thrust_en, stage_sel, sep_pulse, state, burn_count, done, fault
  );
endinterface
`default_nettype wire

// File: rtl/flight_stage_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flight_stage_sequencer : two-stage mission-phase controller              |
// | Optional step-ack watchdog enabled by STEP_WATCHDOG_EN.   Rev 1.0        |
// +--------------------------------------------------------------------------+
module flight_stage_sequencer #(
  parameter int              N              = 64,
  parameter int              STAGE1_BURN    = 160,
  parameter int              STAGE2_BURN    = 400,
  parameter int              COAST_CYCLES   = 8,
  parameter int              SEP_CYCLES     = 4,
  parameter longint unsigned TARGETALTITUDE = 188000,
  parameter longint unsigned ALT_SCALE      = 1_000_000_000
`ifdef STEP_WATCHDOG_EN
  , parameter int            WDOG_CYCLES    = 1024
`endif
) (
  input  wire logic               clk,
  input  wire logic               resetb,
  flight_stage_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_STAGE1   = 3'd1;
  localparam logic [2:0] S_COAST    = 3'd2;
  localparam logic [2:0] S_SEPARATE = 3'd3;
  localparam logic [2:0] S_STAGE2   = 3'd4;
  localparam logic [2:0] S_ORBIT    = 3'd5;
  localparam logic [2:0] S_ABORT    = 3'd6;

  localparam logic [N-1:0] c_target    = N'(TARGETALTITUDE);
  localparam logic [N-1:0] c_scale     = N'(ALT_SCALE);
  localparam logic [N-1:0] c_threshold = c_target * c_scale;

  logic [2:0]  r_state, w_next;
  logic [15:0] r_count;
  logic        r_step_req, r_thrust_en, r_sep_pulse, r_done, r_fault;
  logic [1:0]  r_stage_sel;
  logic        w_step_req, w_thrust_en, w_sep_pulse, w_done, w_fault;
  logic [1:0]  w_stage_sel;
  logic        w_step, w_hit, w_count_en, w_wdog_fire;

  assign w_step = r_step_req & bus.step_ack;
  assign w_hit  = (bus.current_Altitude >= c_threshold);

`ifdef STEP_WATCHDOG_EN
  localparam int c_wdog_w = $clog2(WDOG_CYCLES + 1);
  logic [c_wdog_w-1:0] r_wdog;

  always_ff @(posedge clk) begin
    if (!resetb || !r_step_req || bus.step_ack) r_wdog <= '0;
    else                                         r_wdog <= r_wdog + 1'b1;
  end

  assign w_wdog_fire = r_step_req && !bus.step_ack && (r_wdog == c_wdog_w'(WDOG_CYCLES - 1));
`else
  assign w_wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetb) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Burn counters compare against target-1 because the current step/cycle is the last one
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.launch) w_next = S_STAGE1;
      S_STAGE1: begin
        if (w_step) begin
          if (w_hit)                                       w_next = S_ORBIT;
          else if (r_count == 16'(STAGE1_BURN - 1))        w_next = S_COAST;
        end
      end
      S_COAST:    if (r_count == 16'(COAST_CYCLES - 1))    w_next = S_SEPARATE;
      S_SEPARATE: if (r_count == 16'(SEP_CYCLES - 1))      w_next = S_STAGE2;
      S_STAGE2: begin
        if (w_step) begin
          if (w_hit)                                       w_next = S_ORBIT;
          else if (r_count == 16'(STAGE2_BURN - 1))        w_next = S_ABORT;
        end
      end
      default:    w_next = r_state;
    endcase
    if (w_wdog_fire) w_next = S_ABORT;
    if (bus.abort && (r_state inside {S_STAGE1, S_COAST, S_SEPARATE, S_STAGE2}))
      w_next = S_ABORT;
  end

  // Outputs are decoded from the next state so the registered copies line up with r_state
  always_comb begin
    w_step_req  = (w_next == S_STAGE1) || (w_next == S_COAST) || (w_next == S_STAGE2);
    w_thrust_en = (w_next == S_STAGE1) || (w_next == S_STAGE2);
    w_stage_sel = 2'd0;
    if ((w_next == S_STAGE1) || (w_next == S_COAST)) w_stage_sel = 2'd1;
    if (w_next == S_STAGE2)                         w_stage_sel = 2'd2;
    w_sep_pulse = (w_next == S_SEPARATE) && (r_state != S_SEPARATE);
    w_done      = (w_next == S_ORBIT);
    w_fault     = (w_next == S_ABORT);
  end

  assign w_count_en = (((r_state == S_STAGE1) || (r_state == S_STAGE2)) && w_step) ||
                      (r_state == S_COAST) || (r_state == S_SEPARATE);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_count     <= '0;
      r_step_req  <= 1'b0;
      r_thrust_en <= 1'b0;
      r_stage_sel <= 2'd0;
      r_sep_pulse <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      if (w_next != r_state)                       r_count <= '0;
      else if (w_count_en && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
      r_step_req  <= w_step_req;
      r_thrust_en <= w_thrust_en;
      r_stage_sel <= w_stage_sel;
      r_sep_pulse <= w_sep_pulse;
      r_done      <= w_done;
      r_fault     <= w_fault;
    end
  end

  assign bus.step_req   = r_step_req;
  assign bus.thrust_en  = r_thrust_en;
  assign bus.stage_sel  = r_stage_sel;
  assign bus.sep_pulse  = r_sep_pulse;
  assign bus.state      = r_state;
  assign bus.burn_count = r_count;
  assign bus.done       = r_done;
  assign bus.fault      = r_fault;
endmodule
`default_nettype wire
